drlp_rd_gearbox: RTL and testbench

Parametrised DMA read engine and width-converting buffer feeding the DRLP PE array. It issues sequential DMA word reads from a base address for a programmed length and absorbs returned words in a small credit-controlled FIFO. A gearbox repacks the ELEM_W-bit elements into output words carrying a runtime-selected element count, with a valid/ready handshake downstream. It supersedes the fixed 3x3/4x4/5x5/6x6 packer: any element count, any burst length, backpressure, and a zero-padded final flush.

---
 rtl/drlp_rd_gearbox_if.sv | 25 ++
 rtl/drlp_rd_gearbox.sv | 151 +++++++++++++++
 tb/tb_drlp_rd_gearbox.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drlp_rd_gearbox_if.sv
// DMA read request/return and packed output stream of the DRLP read gearbox.
// master = gearbox side, slave = DMA/consumer side.
interface drlp_rd_gearbox_if #(
    parameter int ADDR_W = 32,
    parameter int IN_W   = 32,
    parameter int OUT_W  = 48
);
    logic              o_dma_rd_en;
    logic [ADDR_W-1:0] o_dma_rd_addr;
    logic              i_dma_valid;
    logic [IN_W-1:0]   i_dma_data;
    logic [OUT_W-1:0]  o_buf_data;
    logic              o_buf_valid;
    logic              i_buf_ready;

    modport master (
        output o_dma_rd_en, o_dma_rd_addr, o_buf_data, o_buf_valid,
        input  i_dma_valid, i_dma_data, i_buf_ready
    );

    modport slave (
        input  o_dma_rd_en, o_dma_rd_addr, o_buf_data, o_buf_valid,
        output i_dma_valid, i_dma_data, i_buf_ready
    );
endinterface

// File: rtl/drlp_rd_gearbox.sv
// DMA read engine with credit-limited return FIFO and element gearbox for the DRLP PE array.
// state | meaning
// IDLE  | waiting for i_start
// RUN   | issuing reads, absorbing returns, emitting packed words
// DRAIN | all returns popped; emitting leftovers and zero-padded flush
// DONE  | one-cycle completion pulse
module drlp_rd_gearbox #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 48,
    parameter int ELEM_W     = 8,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [ADDR_W-1:0]                  i_base_addr,
    input  logic [LEN_W-1:0]                   i_len,
    input  logic [$clog2(OUT_W/ELEM_W):0]      i_out_elems,
    drlp_rd_gearbox_if.master                  bus,
    output logic                               o_busy,
    output logic                               o_done
);
    localparam int E_IN   = IN_W / ELEM_W;
    localparam int E_OUT  = OUT_W / ELEM_W;
    localparam int CAP    = E_IN + E_OUT;
    localparam int ACC_W  = CAP * ELEM_W;
    localparam int CNT_W  = $clog2(CAP + 1);
    localparam int SH_W   = $clog2(ACC_W + 1);
    localparam int NE_W   = $clog2(E_OUT) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int CR_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [CR_W-1:0]    credits;
    logic [CNT_W-1:0]   n_elems;
    logic [IN_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [FCNT_W-1:0]  fcnt;
    logic [ACC_W-1:0]   acc, acc_nx, acc_sh, emit_word;
    logic [CNT_W-1:0]   acc_cnt, cnt_nx, cnt_sh, take;
    logic [SH_W-1:0]    take_bits;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               req, push, pop, fifo_full, fifo_empty, flush, emit;
    logic [CNT_W-1:0]   n_clamp;

    assign req        = (state == S_RUN) && (remaining != '0) && (credits != '0);
    assign push       = bus.i_dma_valid;
    assign fifo_full  = (fcnt == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fcnt == '0);
    // Room check uses the pre-emit count so pop never depends on the output side.
    assign pop        = !fifo_empty && (acc_cnt <= CNT_W'(CAP - E_IN));
    assign flush      = (state == S_DRAIN) && (acc_cnt != '0) && (acc_cnt < n_elems);
    assign emit       = (!out_valid || bus.i_buf_ready) && ((acc_cnt >= n_elems) || flush);
    assign n_clamp    = ((i_out_elems == '0) || (i_out_elems > NE_W'(E_OUT)))
                        ? CNT_W'(E_OUT) : CNT_W'(i_out_elems);

    always_comb begin
        take      = '0;
        if (emit) take = flush ? acc_cnt : n_elems;
        take_bits = SH_W'(take) * SH_W'(ELEM_W);
        cnt_sh    = acc_cnt - take;
        acc_sh    = acc >> take_bits;
        emit_word = acc & ~({ACC_W{1'b1}} << take_bits);
        acc_nx    = acc_sh;
        cnt_nx    = cnt_sh;
        if (pop) begin
            acc_nx = acc_sh | (ACC_W'(fifo_mem[rptr]) << (SH_W'(cnt_sh) * SH_W'(ELEM_W)));
            cnt_nx = cnt_sh + CNT_W'(E_IN);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_start) state_nx = (i_len != '0) ? S_RUN : S_DONE;
            S_RUN:   if ((remaining == '0) && (credits == CR_W'(FIFO_DEPTH))) state_nx = S_DRAIN;
            S_DRAIN: if ((acc_cnt == '0) && !out_valid) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            credits   <= CR_W'(FIFO_DEPTH);
            n_elems   <= CNT_W'(E_OUT);
            wptr      <= '0;
            rptr      <= '0;
            fcnt      <= '0;
            acc       <= '0;
            acc_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == S_IDLE) && i_start) begin
                addr      <= i_base_addr;
                remaining <= i_len;
                n_elems   <= n_clamp;
            end else if (req) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            case ({req, pop})
                2'b10:   credits <= credits - CR_W'(1);
                2'b01:   credits <= credits + CR_W'(1);
                default: credits <= credits;
            endcase
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + FCNT_W'(1);
                2'b01:   fcnt <= fcnt - FCNT_W'(1);
                default: fcnt <= fcnt;
            endcase
            acc     <= acc_nx;
            acc_cnt <= cnt_nx;
            if (emit) begin
                out_data  <= emit_word[OUT_W-1:0];
                out_valid <= 1'b1;
            end else if (bus.i_buf_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wptr] <= bus.i_dma_data;
    end

    // Credits bound outstanding reads to FIFO_DEPTH, so a full FIFO can never see a push.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && fifo_full));

    assign bus.o_dma_rd_en   = req;
    assign bus.o_dma_rd_addr = addr;
    assign bus.o_buf_data    = out_data;
    assign bus.o_buf_valid   = out_valid;
    assign o_busy            = (state != S_IDLE);
    assign o_done            = (state == S_DONE);
endmodule

// File: tb/tb_drlp_rd_gearbox.sv
// Directed bench for drlp_rd_gearbox: DMA model with fixed latency, output collector, scoreboard.
module tb_drlp_rd_gearbox;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic [3:0]  out_elems = '0;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    drlp_rd_gearbox_if #(.ADDR_W(32), .IN_W(32), .OUT_W(48)) bus_if ();

    drlp_rd_gearbox dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .i_out_elems (out_elems),
        .bus         (bus_if),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] addr; int due;} req_t;
    req_t        rq[$];
    logic [31:0] addr_q[$];
    logic [47:0] out_q[$];
    int          acc_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] job_base = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        int w;
        w = int'(a - job_base);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    initial begin
        bus_if.i_dma_valid = 1'b0;
        bus_if.i_dma_data  = '0;
        bus_if.i_buf_ready = 1'b1;
    end

    // DMA returns two cycles after the request is seen; collector records accepted words.
    always @(negedge clk) begin
        if (!rst_n) begin
            rq.delete();
            bus_if.i_dma_valid = 1'b0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus_if.i_dma_valid = 1'b1;
                bus_if.i_dma_data  = word_of(rq[0].addr);
                void'(rq.pop_front());
            end else begin
                bus_if.i_dma_valid = 1'b0;
            end
            if (bus_if.o_dma_rd_en) begin
                rq.push_back('{bus_if.o_dma_rd_addr, cyc + 2});
                addr_q.push_back(bus_if.o_dma_rd_addr);
            end
            if (bus_if.o_buf_valid && bus_if.i_buf_ready) begin
                out_q.push_back(bus_if.o_buf_data);
                acc_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_at(input int i);
        if (i < out_q.size()) return 64'(out_q[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] exp_word(input int first, input int n, input int total);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < n; j++)
            if (first + j < total) w |= 64'((first + j) & 255) << (8 * j);
        return w;
    endfunction

    task automatic start_job(input logic [31:0] b, input int l, input int n);
        @(negedge clk);
        job_base = b;
        addr_q.delete();
        out_q.delete();
        acc_cyc.delete();
        done_cnt  = 0;
        base_addr = b;
        len       = 16'(l);
        out_elems = 4'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_job(input string tag, input logic [31:0] b, input int l, input int n);
        int total, nout;
        total = 4 * l;
        nout  = (total + n - 1) / n;
        check({tag, "_nreq"}, 64'(addr_q.size()), 64'(l));
        for (int i = 0; i < l && i < addr_q.size(); i++)
            check({tag, "_addr"}, 64'(addr_q[i]), 64'(b + 32'(i)));
        check({tag, "_nout"}, 64'(out_q.size()), 64'(nout));
        for (int i = 0; i < nout; i++)
            check({tag, "_data"}, out_at(i), exp_word(i * n, n, total));
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_en",  64'(bus_if.o_dma_rd_en),   64'd0);
        check("rst_addr",   64'(bus_if.o_dma_rd_addr), 64'd0);
        check("rst_valid",  64'(bus_if.o_buf_valid),   64'd0);
        check("rst_data",   64'(bus_if.o_buf_data),    64'd0);
        check("rst_busy",   64'(busy),                 64'd0);
        check("rst_done",   64'(done),                 64'd0);
        rst_n = 1'b1;

        // 3 words into 6-element outputs
        start_job(32'h100, 3, 6);
        wait_done("a");
        check_job("a", 32'h100, 3, 6);
        check("a_out0",  out_at(0), 64'h050403020100);
        check("a_out1",  out_at(1), 64'h0B0A09080706);
        check("a_addr2", 64'(addr_q.size() > 2 ? addr_q[2] : 32'hx), 64'h102);

        // N=4: words pass through, one per cycle
        start_job(32'h200, 5, 4);
        wait_done("b");
        check_job("b", 32'h200, 5, 4);
        check("b_out2", out_at(2), 64'h0B0A0908);
        check("b_rate", 64'(acc_cyc.size() > 3 ? acc_cyc[3] - acc_cyc[0] : -1), 64'd3);

        // N=5 across word boundaries
        start_job(32'h300, 5, 5);
        wait_done("c");
        check_job("c", 32'h300, 5, 5);
        check("c_first", out_at(0), 64'h0403020100);
        check("c_last",  out_at(3), 64'h131211100F);

        // 8 elements at N=6: zero-padded flush
        start_job(32'h380, 2, 6);
        wait_done("d");
        check_job("d", 32'h380, 2, 6);
        check("d_flush", out_at(1), 64'h000000000706);
        check("d_done_after_flush", 64'(acc_cyc.size() > 1 && done_cyc > acc_cyc[1]), 64'd1);

        // backpressure: credits stop requests with FIFO_DEPTH words outstanding
        bus_if.i_buf_ready = 1'b0;
        start_job(32'h400, 16, 6);
        repeat (20) @(negedge clk);
        check("e_stall_nreq",  64'(addr_q.size()),       64'd8);
        check("e_stall_valid", 64'(bus_if.o_buf_valid),  64'd1);
        check("e_stall_data",  64'(bus_if.o_buf_data),   64'h050403020100);
        repeat (5) @(negedge clk);
        check("e_stall_nreq2", 64'(addr_q.size()),       64'd8);
        check("e_stall_data2", 64'(bus_if.o_buf_data),   64'h050403020100);
        check("e_stall_busy",  64'(busy),                64'd1);
        bus_if.i_buf_ready = 1'b1;
        wait_done("e");
        check_job("e", 32'h400, 16, 6);
        check("e_flush", out_at(10), 64'h3F3E3D3C);

        // element count clamping
        start_job(32'h480, 3, 0);
        wait_done("f0");
        check_job("f0", 32'h480, 3, 6);
        start_job(32'h4C0, 3, 15);
        wait_done("f15");
        check_job("f15", 32'h4C0, 3, 6);

        // second start during RUN is ignored
        start_job(32'h500, 6, 6);
        repeat (2) @(negedge clk);
        base_addr = 32'h900;
        len       = 16'd1;
        out_elems = 4'd2;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done("g");
        check_job("g", 32'h500, 6, 6);

        // reset mid-RUN, then zero-length job
        start_job(32'h600, 8, 6);
        repeat (3) @(negedge clk);
        check("h_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("h_rst_rd_en", 64'(bus_if.o_dma_rd_en),   64'd0);
        check("h_rst_addr",  64'(bus_if.o_dma_rd_addr), 64'd0);
        check("h_rst_valid", 64'(bus_if.o_buf_valid),   64'd0);
        check("h_rst_data",  64'(bus_if.o_buf_data),    64'd0);
        check("h_rst_busy",  64'(busy),                 64'd0);
        check("h_rst_done",  64'(done),                 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(32'h700, 0, 6);
        check("h_len0_done",  64'(done), 64'd1);
        check("h_len0_busy",  64'(busy), 64'd1);
        @(negedge clk);
        check("h_len0_done_end", 64'(done), 64'd0);
        check("h_len0_idle",     64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("h_len0_noreq",  64'(addr_q.size()), 64'd0);
        check("h_len0_noout",  64'(out_q.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
